// File: rtl/sram_controller_pkg.sv
`default_nettype none
// sram_controller_pkg: state encoding, 50 MHz wait defaults and counter sizing helper.
// Rev 1.0
package sram_controller_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WSETUP = 3'd2,
    WRITE  = 3'd3,
    WHOLD  = 3'd4
  } sram_ctrl_state_t;

  localparam int SRAM_READ_WAIT  = 1;
  localparam int SRAM_WRITE_WAIT = 1;
  localparam int SRAM_DATA_WIDTH = 32;
  localparam int SRAM_BE_WIDTH   = 4;

  // At least one bit so zero-wait configurations still get a legal counter.
  function automatic int wait_cnt_width(input int read_wait, input int write_wait);
    int max_wait;
    max_wait = (read_wait > write_wait) ? read_wait : write_wait;
    return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_controller_if.sv
`default_nettype none
// sram_controller_if: valid/ready word-request bus and one-cycle response pulse.
// Rev 1.0
interface sram_controller_if #(
  parameter int ADDR_WIDTH = 20
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [3:0]            req_be;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata
  );

endinterface
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// sram_controller: turns word requests into fixed-length asynchronous SRAM cycles.
// Rev 1.0
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int READ_WAIT  = SRAM_READ_WAIT,
  parameter int WRITE_WAIT = SRAM_WRITE_WAIT
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_controller_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [31:0]           ram_data_i,
  output logic [31:0]           ram_data_o,
  output logic                  ram_data_oe,
  output logic                  ram_ce_n,
  output logic                  ram_oe_n,
  output logic                  ram_we_n,
  output logic [3:0]            ram_be_n
);

  localparam int              CNT_W      = wait_cnt_width(READ_WAIT, WRITE_WAIT);
  localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_WAIT);
  localparam logic [CNT_W-1:0] WRITE_LOAD = CNT_W'(WRITE_WAIT);

  sram_ctrl_state_t      state, state_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic                  ce_n_d, oe_n_d, we_n_d, data_oe_d;
  logic [3:0]            be_n_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [31:0]           data_o_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  accept;

  assign bus.req_ready  = (state == IDLE) && !rst;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign accept         = bus.req_valid && bus.req_ready;

  // Next values for every pin; all pins leave through registers below.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    ce_n_d       = ram_ce_n;
    oe_n_d       = ram_oe_n;
    we_n_d       = ram_we_n;
    data_oe_d    = ram_data_oe;
    be_n_d       = ram_be_n;
    addr_d       = ram_addr;
    data_o_d     = ram_data_o;
    resp_rdata_d = resp_rdata_q;
    resp_valid_d = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          addr_d = bus.req_addr;
          be_n_d = ~bus.req_be;
          ce_n_d = 1'b0;
          if (bus.req_we) begin
            state_d   = WSETUP;
            data_o_d  = bus.req_wdata;
            data_oe_d = 1'b1;
          end else begin
            state_d = READ;
            oe_n_d  = 1'b0;
            cnt_d   = READ_LOAD;
          end
        end
      end

      READ: begin
        if (cnt == '0) begin
          resp_rdata_d = ram_data_i;
          resp_valid_d = 1'b1;
          state_d      = IDLE;
          ce_n_d       = 1'b1;
          oe_n_d       = 1'b1;
          be_n_d       = 4'hF;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end

      // Bus is already driven here, so we_n can fall without a turnaround hazard.
      WSETUP: begin
        state_d = WRITE;
        we_n_d  = 1'b0;
        cnt_d   = WRITE_LOAD;
      end

      WRITE: begin
        if (cnt == '0) begin
          state_d = WHOLD;
          we_n_d  = 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end

      WHOLD: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        ce_n_d       = 1'b1;
        data_oe_d    = 1'b0;
        be_n_d       = 4'hF;
      end

      default: begin
        state_d   = IDLE;
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        data_oe_d = 1'b0;
        be_n_d    = 4'hF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ram_ce_n     <= 1'b1;
      ram_oe_n     <= 1'b1;
      ram_we_n     <= 1'b1;
      ram_be_n     <= 4'hF;
      ram_data_oe  <= 1'b0;
      ram_addr     <= '0;
      ram_data_o   <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      ram_ce_n     <= ce_n_d;
      ram_oe_n     <= oe_n_d;
      ram_we_n     <= we_n_d;
      ram_be_n     <= be_n_d;
      ram_data_oe  <= data_oe_d;
      ram_addr     <= addr_d;
      ram_data_o   <= data_o_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`timescale 1ns/1ps
`default_nettype none
// tb_sram_controller: directed stimulus, a cycle-offset timing model and a two-chip SRAM responder.
// Rev 1.0
module tb_sram_controller;
  import sram_controller_pkg::*;

  localparam int AW      = 20;
  localparam int RW      = SRAM_READ_WAIT;
  localparam int WW      = SRAM_WRITE_WAIT;
  localparam int RD_RESP = 2 + RW;
  localparam int WR_RESP = 4 + WW;
  localparam int DEPTH   = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  sram_controller_if #(.ADDR_WIDTH(AW)) bus ();

  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_data_i, ram_data_o;
  logic          ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n;
  logic [3:0]    ram_be_n;

  sram_controller #(.ADDR_WIDTH(AW), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .ram_addr   (ram_addr),
    .ram_data_i (ram_data_i),
    .ram_data_o (ram_data_o),
    .ram_data_oe(ram_data_oe),
    .ram_ce_n   (ram_ce_n),
    .ram_oe_n   (ram_oe_n),
    .ram_we_n   (ram_we_n),
    .ram_be_n   (ram_be_n)
  );

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {8'hC3, b, 8'h5A, ~b};
  endfunction

  // Two 16-bit SRAM chips: async read, write lanes latched while ce_n/we_n are low.
  logic [15:0] mem_lo [DEPTH];
  logic [15:0] mem_hi [DEPTH];
  assign ram_data_i = (!ram_ce_n && !ram_oe_n) ? {mem_hi[ram_addr[7:0]], mem_lo[ram_addr[7:0]]}
                                               : 32'hFFFF_FFFF;
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_lo[i] = init_word(i)[15:0];
      mem_hi[i] = init_word(i)[31:16];
    end
    forever begin
      @(posedge clk);
      if (!ram_ce_n && !ram_we_n) begin
        if (!ram_be_n[0]) mem_lo[ram_addr[7:0]][7:0]  = ram_data_o[7:0];
        if (!ram_be_n[1]) mem_lo[ram_addr[7:0]][15:8] = ram_data_o[15:8];
        if (!ram_be_n[2]) mem_hi[ram_addr[7:0]][7:0]  = ram_data_o[23:16];
        if (!ram_be_n[3]) mem_hi[ram_addr[7:0]][15:8] = ram_data_o[31:24];
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(ram_data_oe && !ram_oe_n))
    else $error("bus contention: data_oe with oe_n low");

  // Model: each transaction is a cycle offset d from its acceptance cycle; pins follow from d.
  logic [31:0] ref_mem [DEPTH];
  initial begin
    bit            mdl_valid, in_reset, txn_act, txn_we, prev_doe;
    int            cyc, txn_t, d;
    logic [AW-1:0] txn_addr;
    logic [31:0]   txn_wdata, txn_exp;
    logic [3:0]    txn_be;
    logic          e_ce, e_oe, e_we, e_doe, e_rv, e_rdy;
    logic [3:0]    e_be;
    mdl_valid = 0; in_reset = 0; txn_act = 0; txn_we = 0; prev_doe = 0;
    cyc = 0; txn_t = 0; d = 0;
    txn_addr = '0; txn_wdata = '0; txn_exp = '0; txn_be = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      cyc++;
      d = cyc - txn_t;
      if (mdl_valid) begin
        e_ce = 1; e_oe = 1; e_we = 1; e_doe = 0; e_be = 4'hF; e_rv = 0; e_rdy = !rst;
        if (in_reset) begin
          chk("rst_addr", 32'(ram_addr), 32'h0);
          chk("rst_data_o", ram_data_o, 32'h0);
          chk("rst_rdata", bus.resp_rdata, 32'h0);
        end else if (txn_act && !txn_we) begin
          if (d <= 1 + RW) begin
            e_ce = 0; e_oe = 0; e_be = ~txn_be; e_rdy = 0;
            chk("rd_addr", 32'(ram_addr), 32'(txn_addr));
          end else begin
            e_rv = 1;
            chk("rd_rdata", bus.resp_rdata, txn_exp);
          end
        end else if (txn_act && txn_we) begin
          if (d <= 3 + WW) begin
            e_ce = 0; e_doe = 1; e_be = ~txn_be; e_rdy = 0;
            e_we = !(d >= 2 && d <= 2 + WW);
            chk("wr_addr", 32'(ram_addr), 32'(txn_addr));
            chk("wr_data_o", ram_data_o, txn_wdata);
          end else begin
            e_rv = 1;
          end
        end
        chk("ce_n", 32'(ram_ce_n), 32'(e_ce));
        chk("oe_n", 32'(ram_oe_n), 32'(e_oe));
        chk("we_n", 32'(ram_we_n), 32'(e_we));
        chk("data_oe", 32'(ram_data_oe), 32'(e_doe));
        chk("be_n", 32'(ram_be_n), 32'(e_be));
        chk("resp_valid", 32'(bus.resp_valid), 32'(e_rv));
        chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
        chk("oe_overlap", 32'(ram_data_oe & ~ram_oe_n), 32'h0);
        if (ram_data_oe != prev_doe) chk("we_at_doe_edge", 32'(ram_we_n), 32'h1);
      end
      prev_doe = ram_data_oe;
      if (rst) begin
        mdl_valid = 1; in_reset = 1; txn_act = 0;
      end else begin
        in_reset = 0;
        if (mdl_valid) begin
          if (txn_act && d == (txn_we ? WR_RESP : RD_RESP)) begin
            if (txn_we)
              for (int b = 0; b < 4; b++)
                if (txn_be[b]) ref_mem[txn_addr[7:0]][8*b +: 8] = txn_wdata[8*b +: 8];
            txn_act = 0;
          end
          if (!txn_act && bus.req_valid) begin
            txn_act   = 1;
            txn_t     = cyc;
            txn_we    = bus.req_we;
            txn_addr  = bus.req_addr;
            txn_wdata = bus.req_wdata;
            txn_be    = bus.req_be;
            txn_exp   = ref_mem[bus.req_addr[7:0]];
          end
        end
      end
    end
  end

  task automatic wait_accept(output int n);
    bit acc;
    acc = 0; n = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = bus.req_ready;
      n++;
      @(posedge clk);
      #1;
    end
    chk("accept_timeout", 32'(acc), 32'h1);
  endtask

  task automatic run_req(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output int lat, output logic [31:0] rd,
                         output logic [3:0] be_seen);
    int  n;
    bit  got;
    @(posedge clk);
    #1;
    bus.req_valid = 1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = wd; bus.req_be = be;
    wait_accept(n);
    bus.req_valid = 0; bus.req_wdata = 32'h0; bus.req_be = 4'h0;
    lat = 0; got = 0; rd = 32'h0; be_seen = 4'h0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!ram_we_n) be_seen = ram_be_n;
      if (bus.resp_valid) begin
        got = 1;
        rd  = bus.resp_rdata;
      end
    end
    chk("resp_timeout", 32'(got), 32'h1);
  endtask

  initial begin
    int          lat, n;
    logic [31:0] rd;
    logic [3:0]  be_seen;
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_be = '0;

    // Reset held for three edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ready_in_rst", 32'(bus.req_ready), 32'h0);
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.req_ready), 32'h1);

    run_req(1'b1, 20'h00010, 32'hDEADBEEF, 4'hF, lat, rd, be_seen);
    chk("wr_latency", 32'(lat), 32'd5);
    chk("wr_be_n", 32'(be_seen), 32'h0);
    chk("mem_hi_10", 32'(mem_hi[8'h10]), 32'h0000DEAD);
    chk("mem_lo_10", 32'(mem_lo[8'h10]), 32'h0000BEEF);

    run_req(1'b0, 20'h00010, 32'h0, 4'hF, lat, rd, be_seen);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_data_full", rd, 32'hDEADBEEF);

    run_req(1'b1, 20'h00010, 32'h0000AB00, 4'b0010, lat, rd, be_seen);
    chk("part_be_n", 32'(be_seen), 32'hD);
    run_req(1'b0, 20'h00010, 32'h0, 4'hF, lat, rd, be_seen);
    chk("rd_data_part", rd, 32'hDEADABEF);

    // Zero byte enables: full cycle and a response, memory untouched.
    run_req(1'b1, 20'h00010, 32'hFFFFFFFF, 4'h0, lat, rd, be_seen);
    chk("be0_latency", 32'(lat), 32'd5);
    chk("be0_be_n", 32'(be_seen), 32'hF);
    run_req(1'b0, 20'h00010, 32'h0, 4'h0, lat, rd, be_seen);
    chk("be0_readback", rd, 32'hDEADABEF);

    // Back-to-back: valid held high, second request lands on the first response cycle.
    @(posedge clk);
    #1;
    bus.req_valid = 1; bus.req_we = 1; bus.req_addr = 20'h00040;
    bus.req_wdata = 32'h12345678; bus.req_be = 4'hF;
    wait_accept(n);
    bus.req_we = 0;
    wait_accept(n);
    chk("b2b_gap", 32'(n), 32'd5);
    bus.req_valid = 0;
    lat = 0; rd = 32'h0;
    while (!bus.resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = bus.resp_rdata;
    chk("b2b_rd_latency", 32'(lat), 32'd3);
    chk("b2b_rd_data", rd, 32'h12345678);

    // Reset during the first WRITE cycle drops the transaction.
    @(posedge clk);
    #1;
    bus.req_valid = 1; bus.req_we = 1; bus.req_addr = 20'h00020;
    bus.req_wdata = 32'h55AA55AA; bus.req_be = 4'hF;
    wait_accept(n);
    bus.req_valid = 0;
    @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    chk("abort_in_write", 32'(ram_we_n), 32'h0);
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("abort_we_n", 32'(ram_we_n), 32'h1);
    chk("abort_ce_n", 32'(ram_ce_n), 32'h1);
    chk("abort_doe", 32'(ram_data_oe), 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_resp", 32'(bus.resp_valid), 32'h0);
    end
    run_req(1'b0, 20'h00030, 32'h0, 4'hF, lat, rd, be_seen);
    chk("post_abort_rd", rd, 32'hC3305ACF);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
